fpcvt_pipe: RTL and testbench

//   Pipelined, parametrised successor to the combinational linear-to-float converter.

---
 rtl/fpcvt_pipe.sv | 134 +++++++++++++
 tb/tb_fpcvt_pipe.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpcvt_pipe.sv
// Three-stage pipelined linear-to-float converter: two's-complement IN_W -> sign/EXP_W/MANT_W.
// Optional macro FPCVT_ROUND_EN enables round-half-up; undefined gives truncation.
module fpcvt_pipe #(
   parameter int IN_W   = 12,
   parameter int EXP_W  = 3,
   parameter int MANT_W = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IN_W-1:0]   in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_sign,
   output logic [EXP_W-1:0]  out_exp,
   output logic [MANT_W-1:0] out_mant,
   output logic              out_sat,
   output logic [CNT_W-1:0]  sat_cnt
);

   localparam int EW = $clog2(IN_W + 2);
   localparam int E_LIM = (IN_W - 1 - MANT_W < 2**EXP_W - 1) ? IN_W - 1 - MANT_W : 2**EXP_W - 1;
   localparam logic [IN_W-1:0] MOST_NEG = {1'b1, {(IN_W-1){1'b0}}};

   logic              adv;
   logic              v1_q, sign1_q, sign1_d, sat1_q, sat1_d;
   logic [IN_W-1:0]   mag1_q, mag1_d;
   logic              v2_q, sign2_q, sat2_q, r2_q, r2_d;
   logic [EW-1:0]     e2_q, e2_d;
   logic [MANT_W-1:0] m2_q, m2_d;
   logic              v3_q, sign3_q, sat3_q, sat3_d;
   logic [EXP_W-1:0]  e3_q, e3_d;
   logic [MANT_W-1:0] m3_q, m3_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   int                lz;
   int                sh;
   logic [MANT_W:0]   msum;
   logic [EW-1:0]     e3_w;

   // The whole pipe moves as one; no bubble collapse.
   assign adv      = out_ready | ~v3_q;
   assign in_ready = adv;

   always_comb begin
      sign1_d = in_data[IN_W-1];
      sat1_d  = 1'b0;
      mag1_d  = in_data;
      if (in_data == MOST_NEG) begin
         mag1_d = ~MOST_NEG;
         sat1_d = 1'b1;
      end else if (sign1_d) begin
         mag1_d = -in_data;
      end
   end

   always_comb begin
      lz = IN_W;
      for (int i = 0; i < IN_W; i++) begin
         if (mag1_q[i]) lz = IN_W - 1 - i;
      end
      sh   = IN_W - MANT_W - lz;
      e2_d = '0;
      m2_d = mag1_q[MANT_W-1:0];
      r2_d = 1'b0;
      if (sh > 0) begin
         e2_d = EW'(sh);
         m2_d = MANT_W'(mag1_q >> sh);
`ifdef FPCVT_ROUND_EN
         r2_d = 1'(mag1_q >> (sh - 1));
`endif
      end
   end

   // Without rounding r2 is always 0, so the overflow/clamp paths below never fire.
   always_comb begin
      msum   = {1'b0, m2_q} + {{MANT_W{1'b0}}, r2_q};
      e3_w   = e2_q;
      sat3_d = sat2_q;
      if (msum[MANT_W]) begin
         msum = {2'b01, {(MANT_W-1){1'b0}}};
         e3_w = e2_q + EW'(1);
      end
      if (e3_w > EW'(E_LIM)) begin
         e3_w   = EW'(E_LIM);
         msum   = {1'b0, {MANT_W{1'b1}}};
         sat3_d = 1'b1;
      end
      m3_d = msum[MANT_W-1:0];
      e3_d = EXP_W'(e3_w);
   end

   always_comb begin
      cnt_d = cnt_q;
      if (v3_q && out_ready && sat3_q && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q <= 1'b0; sign1_q <= 1'b0; sat1_q <= 1'b0; mag1_q <= '0;
         v2_q <= 1'b0; sign2_q <= 1'b0; sat2_q <= 1'b0; r2_q <= 1'b0; e2_q <= '0; m2_q <= '0;
         v3_q <= 1'b0; sign3_q <= 1'b0; sat3_q <= 1'b0; e3_q <= '0; m3_q <= '0;
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (adv) begin
            v1_q    <= in_valid;
            sign1_q <= sign1_d;
            sat1_q  <= sat1_d;
            mag1_q  <= mag1_d;
            v2_q    <= v1_q;
            sign2_q <= sign1_q;
            sat2_q  <= sat1_q;
            r2_q    <= r2_d;
            e2_q    <= e2_d;
            m2_q    <= m2_d;
            v3_q    <= v2_q;
            sign3_q <= sign2_q;
            sat3_q  <= sat3_d;
            e3_q    <= e3_d;
            m3_q    <= m3_d;
         end
      end
   end

   assign out_valid = v3_q;
   assign out_sign  = sign3_q;
   assign out_exp   = e3_q;
   assign out_mant  = m3_q;
   assign out_sat   = sat3_q;
   assign sat_cnt   = cnt_q;

endmodule

// File: tb/tb_fpcvt_pipe.sv
// Self-checking bench for fpcvt_pipe: directed cases, stall/order checks, random stream, async reset.
module tb_fpcvt_pipe;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [11:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        out_sign;
   logic [2:0]  out_exp;
   logic [3:0]  out_mant;
   logic        out_sat;
   logic [15:0] sat_cnt;

   typedef struct packed {
      logic       s;
      logic [2:0] e;
      logic [3:0] m;
      logic       sat;
   } res_t;

   res_t q[$];
   res_t prev_out;
   bit   prev_stall = 0;
   bit   last_acc = 0;
   int   checks = 0;
   int   failures = 0;
   int   sat_exp = 0;
   int   sent;

   fpcvt_pipe dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sign(out_sign), .out_exp(out_exp), .out_mant(out_mant),
      .out_sat(out_sat), .sat_cnt(sat_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   // Reference: float value from plain arithmetic on the integer magnitude.
   function automatic res_t model(input logic [11:0] d);
      res_t res;
      int v, mag, e, m, r, hi;
      v = $signed(d);
      res.s = d[11];
      res.sat = 1'b0;
      if (v == -2048) begin
         mag = 2047;
         res.sat = 1'b1;
      end else begin
         mag = (v < 0) ? -v : v;
      end
      if (mag < 16) begin
         e = 0; m = mag; r = 0;
      end else begin
         hi = 0;
         while ((mag >> (hi + 1)) != 0) hi++;
         e = hi - 3;
         m = mag >> e;
         r = (mag >> (e - 1)) & 1;
      end
`ifndef FPCVT_ROUND_EN
      r = 0;
`endif
      m = m + r;
      if (m == 16) begin
         m = 8;
         e = e + 1;
      end
      if (e > 7) begin
         e = 7; m = 15; res.sat = 1'b1;
      end
      res.e = 3'(e);
      res.m = 4'(m);
      return res;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      res_t cur, e;
      @(negedge clk);
      cur = {out_sign, out_exp, out_mant, out_sat};
      check("sat_cnt", 32'(sat_cnt), 32'(sat_exp));
      if (prev_stall) begin
         check("stall_valid", 32'(out_valid), 32'd1);
         check("stall_hold", 32'(cur), 32'(prev_out));
      end
      if (out_valid && !out_ready) check("stall_in_ready", 32'(in_ready), 32'd0);
      if (out_valid && out_ready) begin
         if (q.size() == 0) begin
            check("unexpected_out", 32'(q.size()), 32'd1);
         end else begin
            e = q.pop_front();
            check("result", 32'(cur), 32'(e));
            if (e.sat && sat_exp < 65535) sat_exp++;
         end
      end
      last_acc = in_valid && in_ready;
      if (last_acc) q.push_back(model(in_data));
      prev_stall = out_valid && !out_ready;
      prev_out = cur;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20 && q.size() > 0; i++) tick();
      check("drain", 32'(q.size()), 32'd0);
   endtask

   logic [11:0] dir_vec [5];

   initial begin
      #3;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_outs", {out_sign, out_exp, out_mant, out_sat}, 32'd0);
      check("rst_sat_cnt", 32'(sat_cnt), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // Latency of one sample, with the documented mantissa.
      in_data = 12'b000110010010;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("lat_c1", 32'(out_valid), 32'd0);
      tick();
      check("lat_c2", 32'(out_valid), 32'd0);
      tick();
      check("lat_c3", 32'(out_valid), 32'd1);
      check("t1_sign", 32'(out_sign), 32'd0);
      check("t1_exp", 32'(out_exp), 32'd5);
`ifdef FPCVT_ROUND_EN
      check("t1_mant", 32'(out_mant), 32'hD);
`else
      check("t1_mant", 32'(out_mant), 32'hC);
`endif
      check("t1_sat", 32'(out_sat), 32'd0);
      drain();

      // Zero, -1, round overflow, max positive, most negative; back to back.
      dir_vec[0] = 12'h000;
      dir_vec[1] = 12'hFFF;
      dir_vec[2] = 12'b000011111000;
      dir_vec[3] = 12'h7FF;
      dir_vec[4] = 12'h800;
      for (int i = 0; i < 5; i++) begin
         in_data = dir_vec[i];
         in_valid = 1'b1;
         tick();
      end
      drain();
      tick();
`ifdef FPCVT_ROUND_EN
      check("t4_sat_cnt", 32'(sat_cnt), 32'd2);
`else
      check("t4_sat_cnt", 32'(sat_cnt), 32'd1);
`endif

      // Eight-sample stream with the sink stalled on cycles 4-6.
      sent = 0;
      in_data = 12'($urandom);
      for (int c = 1; c <= 40 && (sent < 8 || q.size() > 0); c++) begin
         out_ready = !(c >= 4 && c <= 6);
         in_valid = (sent < 8);
         tick();
         if (last_acc) begin
            sent++;
            in_data = 12'($urandom);
         end
      end
      check("stream_sent", 32'(sent), 32'd8);
      drain();

      // Random traffic with random backpressure, including extreme codes.
      for (int c = 0; c < 400; c++) begin
         in_valid = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(3) != 0);
         case ($urandom_range(7))
            0: in_data = 12'h800;
            1: in_data = 12'h7FF;
            2: in_data = 12'($urandom_range(31));
            default: in_data = 12'($urandom);
         endcase
         tick();
      end
      drain();

      // Asynchronous reset with three samples in flight.
      in_valid = 1'b1;
      in_data = 12'h800;
      tick();
      in_data = 12'h123;
      tick();
      in_data = 12'hE01;
      tick();
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_sat_cnt", 32'(sat_cnt), 32'd0);
      check("arst_outs", {out_sign, out_exp, out_mant, out_sat}, 32'd0);
      q.delete();
      sat_exp = 0;
      prev_stall = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      in_data = 12'h0F8;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("post_rst_c1", 32'(out_valid), 32'd0);
      tick();
      check("post_rst_c2", 32'(out_valid), 32'd0);
      tick();
      check("post_rst_c3", 32'(out_valid), 32'd1);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
